// File: rtl/dm_sba_ext.sv
// -----------------------------------------------------------------------------
// dm_sba_ext
// System bus access master for the debug module. It runs one debug-initiated
// read or write at a time on the system bus for the DM CSR block. The bus is
// 32 or 64 bits wide, and sub-word accesses are steered onto the matching byte
// lanes. Size and alignment are checked before a transaction starts, and an
// optional timeout ends a bus cycle that never completes.
//
// Ports
//   clk_i, rst_ni             clock, synchronous active-low reset
//   dmactive_i                0 clears the block in the same way as reset
//   sbaddress_i/_write_valid  address load from the CSR block
//   sbreadonaddr_i            start a read when the address is written
//   sbreadondata_i            start a read when sbdata is read
//   sbautoincrement_i         step the address after a successful access
//   sbaccess_i                log2 of the access size in bytes
//   sbdata_i                  write data
//   sbdata_write_valid_i      sbdata written by the debugger (starts a write)
//   sbdata_read_valid_i       sbdata read by the debugger
//   sbaddress_o               current address
//   sbdata_o/_valid_o         read result (right-aligned) and update pulse
//   sbbusy_o                  transaction in progress
//   sberror_valid_o/sberror_o error pulse and error code
//   master_*                  system bus host port
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transaction; accepts triggers and address loads
// REQ_RD  | read request on the bus, waiting for the grant
// REQ_WR  | write request on the bus, waiting for the grant
// WAIT_RD | read granted, waiting for the response
// WAIT_WR | write granted, waiting for the response
// -----------------------------------------------------------------------------
module dm_sba_ext #(
    parameter int unsigned BusWidth       = 32,
    parameter bit          ReadByteEnable = 1'b1,
    parameter int unsigned TimeoutCycles  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbreadondata_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_write_valid_i,
    input  logic                  sbdata_read_valid_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sberror_valid_o,
    output logic [2:0]            sberror_o,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic                  master_r_other_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i
);

    localparam int unsigned BeW = BusWidth / 8;
    localparam int unsigned L   = $clog2(BeW);
    // A zero-width counter is not legal, so keep at least one bit even
    // when the timeout is disabled.
    localparam int unsigned TW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TW-1:0] TmoLast = (TimeoutCycles > 0) ? TW'(TimeoutCycles - 1) : '0;

    localparam logic [2:0] ErrTimeout = 3'd1;
    localparam logic [2:0] ErrBus     = 3'd2;
    localparam logic [2:0] ErrAlign   = 3'd3;
    localparam logic [2:0] ErrSize    = 3'd4;
    localparam logic [2:0] ErrOther   = 3'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_RD  = 3'd1,
        REQ_WR  = 3'd2,
        WAIT_RD = 3'd3,
        WAIT_WR = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic [BusWidth-1:0]   r_sbaddress;
    logic [2:0]            r_access;
    logic [BusWidth-1:0]   r_wdata;
    logic [TW-1:0]         r_tmo_cnt;
    logic [BusWidth-1:0]   r_sbdata;
    logic                  r_sbdata_valid;
    logic                  r_sberror_valid;
    logic [2:0]            r_sberror;

    state_t                w_state_nxt;
    logic [BusWidth-1:0]   w_addr_nxt;
    logic [2:0]            w_access_nxt;
    logic [BusWidth-1:0]   w_wdata_nxt;
    logic [TW-1:0]         w_tmo_nxt;
    logic [BusWidth-1:0]   w_sbdata_nxt;
    logic                  w_sbdata_valid_nxt;
    logic                  w_err_valid_nxt;
    logic [2:0]            w_err_nxt;

    logic [BusWidth-1:0]   w_start_addr;
    logic [L-1:0]          w_start_off;
    logic                  w_start_wr;
    logic                  w_start_rd;
    logic                  w_size_bad;
    logic [L-1:0]          w_align_mask;
    logic                  w_align_bad;
    logic [L-1:0]          w_off;
    logic [BeW-1:0]        w_be_base;
    logic [BeW-1:0]        w_be;
    logic [BusWidth-1:0]   w_rd_mask;
    logic [BusWidth-1:0]   w_rdata_sh;
    logic [BusWidth-1:0]   w_incr;
    logic [TW-1:0]         w_tmo_inc;
    logic                  w_tmo_hit;

    // ---------------------------------------------------------------------
    // Start qualification. A read triggered together with an address load
    // uses the freshly written address.
    // ---------------------------------------------------------------------
    assign w_start_addr = sbaddress_write_valid_i ? sbaddress_i : r_sbaddress;
    assign w_start_off  = w_start_addr[L-1:0];
    assign w_start_wr   = sbdata_write_valid_i;
    assign w_start_rd   = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                          (sbdata_read_valid_i && sbreadondata_i);
    assign w_size_bad   = (32'(sbaccess_i) > L);

    always_comb begin
        w_align_mask = '0;
        for (int i = 0; i < int'(L); i++) begin
            w_align_mask[i] = (i < int'(sbaccess_i));
        end
    end

    assign w_align_bad = |(w_start_off & w_align_mask);

    // ---------------------------------------------------------------------
    // Lane steering for the transaction in flight.
    // ---------------------------------------------------------------------
    assign w_off = r_sbaddress[L-1:0];

    always_comb begin
        w_be_base = '0;
        for (int i = 0; i < int'(BeW); i++) begin
            w_be_base[i] = (i < (1 << r_access));
        end
    end

    always_comb begin
        w_rd_mask = '0;
        for (int i = 0; i < int'(BusWidth); i++) begin
            w_rd_mask[i] = (i < (8 << r_access));
        end
    end

    assign w_be       = w_be_base << w_off;
    assign w_rdata_sh = master_r_rdata_i >> {w_off, 3'b000};
    assign w_incr     = {{(BusWidth-1){1'b0}}, 1'b1} << r_access;

    // The counter stays at zero while the timeout is disabled.
    assign w_tmo_inc = (TimeoutCycles > 0) ? (r_tmo_cnt + 1'b1) : '0;
    assign w_tmo_hit = (TimeoutCycles > 0) && (r_tmo_cnt == TmoLast);

    // ---------------------------------------------------------------------
    // Next state and next register values
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_addr_nxt         = r_sbaddress;
        w_access_nxt       = r_access;
        w_wdata_nxt        = r_wdata;
        w_tmo_nxt          = '0;
        w_sbdata_nxt       = r_sbdata;
        w_sbdata_valid_nxt = 1'b0;
        w_err_valid_nxt    = 1'b0;
        w_err_nxt          = r_sberror;

        unique case (r_state)
            IDLE: begin
                if (sbaddress_write_valid_i) begin
                    w_addr_nxt = sbaddress_i;
                end
                // A write wins over a read started in the same cycle.
                if (w_start_wr || w_start_rd) begin
                    if (w_size_bad) begin
                        w_err_valid_nxt = 1'b1;
                        w_err_nxt       = ErrSize;
                    end else if (w_align_bad) begin
                        w_err_valid_nxt = 1'b1;
                        w_err_nxt       = ErrAlign;
                    end else begin
                        w_state_nxt  = w_start_wr ? REQ_WR : REQ_RD;
                        w_access_nxt = sbaccess_i;
                        w_wdata_nxt  = sbdata_i;
                    end
                end
            end

            REQ_RD, REQ_WR: begin
                w_tmo_nxt = w_tmo_inc;
                // A grant arriving together with the timeout limit still wins.
                if (master_gnt_i) begin
                    w_state_nxt = (r_state == REQ_WR) ? WAIT_WR : WAIT_RD;
                end else if (w_tmo_hit) begin
                    w_state_nxt     = IDLE;
                    w_err_valid_nxt = 1'b1;
                    w_err_nxt       = ErrTimeout;
                end
            end

            WAIT_RD, WAIT_WR: begin
                w_tmo_nxt = w_tmo_inc;
                if (master_r_valid_i) begin
                    w_state_nxt = IDLE;
                    if (master_r_other_err_i) begin
                        w_err_valid_nxt = 1'b1;
                        w_err_nxt       = ErrOther;
                    end else if (master_r_err_i) begin
                        w_err_valid_nxt = 1'b1;
                        w_err_nxt       = ErrBus;
                    end else begin
                        if (r_state == WAIT_RD) begin
                            w_sbdata_nxt       = w_rdata_sh & w_rd_mask;
                            w_sbdata_valid_nxt = 1'b1;
                        end
                        if (sbautoincrement_i) begin
                            w_addr_nxt = r_sbaddress + w_incr;
                        end
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt     = IDLE;
                    w_err_valid_nxt = 1'b1;
                    w_err_nxt       = ErrTimeout;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !dmactive_i) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_sbaddress     <= '0;
            r_access        <= '0;
            r_wdata         <= '0;
            r_tmo_cnt       <= '0;
            r_sbdata        <= '0;
            r_sbdata_valid  <= 1'b0;
            r_sberror_valid <= 1'b0;
            r_sberror       <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_busy          <= (w_state_nxt != IDLE);
            r_sbaddress     <= w_addr_nxt;
            r_access        <= w_access_nxt;
            r_wdata         <= w_wdata_nxt;
            r_tmo_cnt       <= w_tmo_nxt;
            r_sbdata        <= w_sbdata_nxt;
            r_sbdata_valid  <= w_sbdata_valid_nxt;
            r_sberror_valid <= w_err_valid_nxt;
            r_sberror       <= w_err_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Bus outputs depend only on registered state, so they hold stable
    // through a request phase until the grant.
    // ---------------------------------------------------------------------
    always_comb begin
        master_req_o   = 1'b0;
        master_we_o    = 1'b0;
        master_add_o   = '0;
        master_wdata_o = '0;
        master_be_o    = '0;
        unique case (r_state)
            REQ_RD: begin
                master_req_o = 1'b1;
                master_add_o = {r_sbaddress[BusWidth-1:L], {L{1'b0}}};
                master_be_o  = ReadByteEnable ? w_be : '0;
            end
            REQ_WR: begin
                master_req_o   = 1'b1;
                master_we_o    = 1'b1;
                master_add_o   = {r_sbaddress[BusWidth-1:L], {L{1'b0}}};
                master_be_o    = w_be;
                master_wdata_o = r_wdata << {w_off, 3'b000};
            end
            default: begin
            end
        endcase
    end

    assign sbaddress_o     = r_sbaddress;
    assign sbdata_o        = r_sbdata;
    assign sbdata_valid_o  = r_sbdata_valid;
    assign sbbusy_o        = r_busy;
    assign sberror_valid_o = r_sberror_valid;
    assign sberror_o       = r_sberror;

endmodule

// File: tb/tb_dm_sba_ext.sv
module tb_dm_sba_ext;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 64-bit bus, no timeout, read byte enables driven
    logic        a_dmactive = 1'b1;
    logic [63:0] a_addr_i = '0;
    logic        a_addr_wv = 1'b0, a_rd_on_addr = 1'b0, a_rd_on_data = 1'b0, a_autoinc = 1'b0;
    logic [2:0]  a_access = '0;
    logic [63:0] a_sbdata_i = '0;
    logic        a_data_wv = 1'b0, a_data_rv = 1'b0;
    logic [63:0] a_addr_o, a_sbdata_o;
    logic        a_sbdata_valid, a_busy, a_err_valid;
    logic [2:0]  a_err;
    logic        a_req, a_we;
    logic [63:0] a_add, a_wdata;
    logic [7:0]  a_be;
    logic        a_gnt = 1'b0, a_rvalid = 1'b0, a_rerr = 1'b0, a_roerr = 1'b0;
    logic [63:0] a_rdata = '0;

    // DUT B: 32-bit bus, timeout 8, read byte enables suppressed
    logic        b_dmactive = 1'b1;
    logic [31:0] b_addr_i = '0;
    logic        b_addr_wv = 1'b0, b_rd_on_addr = 1'b0, b_rd_on_data = 1'b0, b_autoinc = 1'b0;
    logic [2:0]  b_access = '0;
    logic [31:0] b_sbdata_i = '0;
    logic        b_data_wv = 1'b0, b_data_rv = 1'b0;
    logic [31:0] b_addr_o, b_sbdata_o;
    logic        b_sbdata_valid, b_busy, b_err_valid;
    logic [2:0]  b_err;
    logic        b_req, b_we;
    logic [31:0] b_add, b_wdata;
    logic [3:0]  b_be;
    logic        b_gnt = 1'b0, b_rvalid = 1'b0, b_rerr = 1'b0, b_roerr = 1'b0;
    logic [31:0] b_rdata = '0;

    dm_sba_ext #(.BusWidth(64), .ReadByteEnable(1'b1), .TimeoutCycles(0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(a_dmactive),
        .sbaddress_i(a_addr_i), .sbaddress_write_valid_i(a_addr_wv),
        .sbreadonaddr_i(a_rd_on_addr), .sbreadondata_i(a_rd_on_data),
        .sbautoincrement_i(a_autoinc), .sbaccess_i(a_access),
        .sbdata_i(a_sbdata_i), .sbdata_write_valid_i(a_data_wv), .sbdata_read_valid_i(a_data_rv),
        .sbaddress_o(a_addr_o), .sbdata_o(a_sbdata_o), .sbdata_valid_o(a_sbdata_valid),
        .sbbusy_o(a_busy), .sberror_valid_o(a_err_valid), .sberror_o(a_err),
        .master_req_o(a_req), .master_add_o(a_add), .master_we_o(a_we),
        .master_wdata_o(a_wdata), .master_be_o(a_be),
        .master_gnt_i(a_gnt), .master_r_valid_i(a_rvalid), .master_r_err_i(a_rerr),
        .master_r_other_err_i(a_roerr), .master_r_rdata_i(a_rdata)
    );

    dm_sba_ext #(.BusWidth(32), .ReadByteEnable(1'b0), .TimeoutCycles(8)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(b_dmactive),
        .sbaddress_i(b_addr_i), .sbaddress_write_valid_i(b_addr_wv),
        .sbreadonaddr_i(b_rd_on_addr), .sbreadondata_i(b_rd_on_data),
        .sbautoincrement_i(b_autoinc), .sbaccess_i(b_access),
        .sbdata_i(b_sbdata_i), .sbdata_write_valid_i(b_data_wv), .sbdata_read_valid_i(b_data_rv),
        .sbaddress_o(b_addr_o), .sbdata_o(b_sbdata_o), .sbdata_valid_o(b_sbdata_valid),
        .sbbusy_o(b_busy), .sberror_valid_o(b_err_valid), .sberror_o(b_err),
        .master_req_o(b_req), .master_add_o(b_add), .master_we_o(b_we),
        .master_wdata_o(b_wdata), .master_be_o(b_be),
        .master_gnt_i(b_gnt), .master_r_valid_i(b_rvalid), .master_r_err_i(b_rerr),
        .master_r_other_err_i(b_roerr), .master_r_rdata_i(b_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(); tick(); tick();
        chk("rst_a_busy",  64'(a_busy), 64'h0);
        chk("rst_a_req",   64'(a_req), 64'h0);
        chk("rst_a_addr",  a_addr_o, 64'h0);
        chk("rst_b_sbdata", 64'(b_sbdata_o), 64'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- A: byte write at 0x1003 ----------------
        a_addr_i = 64'h1003; a_addr_wv = 1'b1;
        tick();
        a_addr_wv = 1'b0; a_access = 3'd0; a_sbdata_i = 64'hA5; a_data_wv = 1'b1;
        tick();                                   // cycle N+1
        a_data_wv = 1'b0;
        chk("wb_busy",  64'(a_busy), 64'h1);
        chk("wb_req",   64'(a_req), 64'h1);
        chk("wb_we",    64'(a_we), 64'h1);
        chk("wb_add",   a_add, 64'h1000);
        chk("wb_be",    64'(a_be), 64'h08);
        chk("wb_wdata", a_wdata, 64'h0000_0000_A500_0000);
        a_gnt = 1'b1;
        tick();                                   // N+2
        a_gnt = 1'b0;
        chk("wb_wait_req",  64'(a_req), 64'h0);
        chk("wb_wait_busy", 64'(a_busy), 64'h1);
        a_rvalid = 1'b1;
        tick();                                   // N+3
        a_rvalid = 1'b0;
        chk("wb_done_busy", 64'(a_busy), 64'h0);
        chk("wb_done_err",  64'(a_err_valid), 64'h0);
        chk("wb_done_addr", a_addr_o, 64'h1003);

        // ---------------- A: halfword read at 0x2006 (read on address) ----
        a_addr_i = 64'h2006; a_addr_wv = 1'b1; a_rd_on_addr = 1'b1; a_access = 3'd1;
        tick();                                   // N+1
        a_addr_wv = 1'b0; a_rd_on_addr = 1'b0;
        chk("rh_req",  64'(a_req), 64'h1);
        chk("rh_we",   64'(a_we), 64'h0);
        chk("rh_add",  a_add, 64'h2000);
        chk("rh_be",   64'(a_be), 64'hC0);
        tick();                                   // grant stalled one cycle
        chk("rh_hold_req", 64'(a_req), 64'h1);
        chk("rh_hold_add", a_add, 64'h2000);
        a_gnt = 1'b1;
        tick();
        a_gnt = 1'b0;
        chk("rh_wait_req", 64'(a_req), 64'h0);
        a_rvalid = 1'b1; a_rdata = 64'h1234_5678_9ABC_DEF0;
        tick();
        a_rvalid = 1'b0;
        chk("rh_valid",  64'(a_sbdata_valid), 64'h1);
        chk("rh_data",   a_sbdata_o, 64'h1234);
        chk("rh_busy",   64'(a_busy), 64'h0);
        chk("rh_addr",   a_addr_o, 64'h2006);
        tick();
        chk("rh_pulse",  64'(a_sbdata_valid), 64'h0);

        // ---------------- A: write with both error flags -> 7 -----------
        a_autoinc = 1'b1; a_access = 3'd1; a_sbdata_i = 64'hBEEF; a_data_wv = 1'b1;
        tick();
        a_data_wv = 1'b0;
        chk("we7_be",    64'(a_be), 64'hC0);
        chk("we7_wdata", a_wdata, 64'hBEEF_0000_0000_0000);
        a_gnt = 1'b1;
        tick();
        a_gnt = 1'b0;
        a_rvalid = 1'b1; a_rerr = 1'b1; a_roerr = 1'b1;
        tick();
        a_rvalid = 1'b0; a_rerr = 1'b0; a_roerr = 1'b0;
        chk("we7_evalid", 64'(a_err_valid), 64'h1);
        chk("we7_code",   64'(a_err), 64'h7);
        chk("we7_addr",   a_addr_o, 64'h2006);

        // ---------------- A: read with bus error -> 2 --------------------
        a_rd_on_data = 1'b1; a_data_rv = 1'b1;
        tick();
        a_data_rv = 1'b0;
        a_gnt = 1'b1;
        tick();
        a_gnt = 1'b0;
        a_rvalid = 1'b1; a_rerr = 1'b1; a_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        a_rvalid = 1'b0; a_rerr = 1'b0;
        chk("re2_code",   64'(a_err), 64'h2);
        chk("re2_dvalid", 64'(a_sbdata_valid), 64'h0);
        chk("re2_data",   a_sbdata_o, 64'h1234);
        chk("re2_addr",   a_addr_o, 64'h2006);
        a_rd_on_data = 1'b0;

        // ---------------- A: misaligned word at 0x1002 -> 3 --------------
        a_addr_i = 64'h1002; a_addr_wv = 1'b1;
        tick();
        a_addr_wv = 1'b0; a_access = 3'd2; a_data_wv = 1'b1;
        tick();
        a_data_wv = 1'b0;
        chk("al3_evalid", 64'(a_err_valid), 64'h1);
        chk("al3_code",   64'(a_err), 64'h3);
        chk("al3_busy",   64'(a_busy), 64'h0);
        chk("al3_req",    64'(a_req), 64'h0);
        tick();
        chk("al3_pulse",  64'(a_err_valid), 64'h0);

        // ---------------- A: write and read trigger together ------------
        a_addr_i = 64'h1008; a_addr_wv = 1'b1;
        tick();
        a_addr_wv = 1'b0;
        a_access = 3'd3; a_sbdata_i = 64'h1122_3344_5566_7788;
        a_data_wv = 1'b1; a_data_rv = 1'b1; a_rd_on_data = 1'b1;
        tick();
        a_data_wv = 1'b0; a_data_rv = 1'b0; a_rd_on_data = 1'b0;
        chk("wr_we",    64'(a_we), 64'h1);
        chk("wr_be",    64'(a_be), 64'hFF);
        chk("wr_wdata", a_wdata, 64'h1122_3344_5566_7788);
        a_gnt = 1'b1;
        tick();
        a_gnt = 1'b0;
        a_rvalid = 1'b1;
        tick();
        a_rvalid = 1'b0;
        chk("wr_dvalid", 64'(a_sbdata_valid), 64'h0);
        chk("wr_addr",   a_addr_o, 64'h1010);
        tick();
        chk("wr_no_rd_req",  64'(a_req), 64'h0);
        chk("wr_no_rd_busy", 64'(a_busy), 64'h0);

        // ---------------- A: dmactive drop in WAIT_RD --------------------
        a_access = 3'd2; a_rd_on_data = 1'b1; a_data_rv = 1'b1;
        tick();
        a_data_rv = 1'b0; a_rd_on_data = 1'b0;
        a_gnt = 1'b1;
        tick();
        a_gnt = 1'b0;
        chk("dm_wait_busy", 64'(a_busy), 64'h1);
        a_dmactive = 1'b0;
        tick();
        a_dmactive = 1'b1;
        chk("dm_busy",   64'(a_busy), 64'h0);
        chk("dm_addr",   a_addr_o, 64'h0);
        chk("dm_sbdata", a_sbdata_o, 64'h0);
        chk("dm_req",    64'(a_req), 64'h0);
        chk("dm_err",    64'(a_err), 64'h0);

        // ---------------- B: doubleword on a 32-bit bus -> 4 ------------
        b_access = 3'd3; b_data_wv = 1'b1;
        tick();
        b_data_wv = 1'b0;
        chk("sz4_evalid", 64'(b_err_valid), 64'h1);
        chk("sz4_code",   64'(b_err), 64'h4);
        chk("sz4_req",    64'(b_req), 64'h0);
        chk("sz4_busy",   64'(b_busy), 64'h0);

        // ---------------- B: autoincrement wrap -------------------------
        b_addr_i = 32'hFFFF_FFFC; b_addr_wv = 1'b1;
        tick();
        b_addr_wv = 1'b0;
        b_access = 3'd2; b_rd_on_data = 1'b1; b_autoinc = 1'b1; b_data_rv = 1'b1;
        tick();
        b_data_rv = 1'b0;
        chk("ai1_add", 64'(b_add), 64'hFFFF_FFFC);
        b_gnt = 1'b1;
        tick();
        b_gnt = 1'b0;
        b_rvalid = 1'b1; b_rdata = 32'hDEAD_BEEF;
        tick();
        b_rvalid = 1'b0;
        chk("ai1_data", 64'(b_sbdata_o), 64'hDEAD_BEEF);
        chk("ai1_addr", 64'(b_addr_o), 64'h0);
        b_data_rv = 1'b1;
        tick();
        b_data_rv = 1'b0;
        chk("ai2_add", 64'(b_add), 64'h0);
        b_gnt = 1'b1;
        tick();
        b_gnt = 1'b0;
        b_rvalid = 1'b1; b_rdata = 32'h5A5A_1234;
        tick();
        b_rvalid = 1'b0;
        chk("ai2_valid", 64'(b_sbdata_valid), 64'h1);
        chk("ai2_data",  64'(b_sbdata_o), 64'h5A5A_1234);
        chk("ai2_addr",  64'(b_addr_o), 64'h4);

        // ---------------- B: timeout with grant withheld ----------------
        b_data_rv = 1'b1;
        tick();                                   // N+1
        b_data_rv = 1'b0;
        chk("to_be_rd", 64'(b_be), 64'h0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("to_busy%0d", k), 64'(b_busy & b_req), 64'h1);
            tick();
        end
        chk("to_evalid", 64'(b_err_valid), 64'h1);
        chk("to_code",   64'(b_err), 64'h1);
        chk("to_busy",   64'(b_busy), 64'h0);
        b_rvalid = 1'b1; b_rdata = 32'hFFFF_FFFF;
        tick();
        b_rvalid = 1'b0;
        chk("to_late_dvalid", 64'(b_sbdata_valid), 64'h0);
        chk("to_late_evalid", 64'(b_err_valid), 64'h0);
        chk("to_late_data",   64'(b_sbdata_o), 64'h5A5A_1234);
        chk("to_late_addr",   64'(b_addr_o), 64'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
